// File: rtl/freq_update_ctrl.sv
// ---------------------------------------------------------------------------
// freq_update_ctrl
//
// Sequences tuning-word updates for the DDS core. Each FreqChng event from
// the rotary front end latches a (clamped) frequency index. The controller
// reads the matching tuning word from the synchronous frequency ROM and holds
// it in a shadow register. It hands that word to the phase accumulator only at
// a phase-wrap boundary, so the output waveform never glitches. If no wrap
// arrives within WRAP_TMO cycles, the word is committed anyway. This covers
// the case of a frozen accumulator (tw_out = 0), which never wraps.
//
// Ports:
//   Fg_clk      in   system clock
//   Reset       in   asynchronous reset, active-high
//   FreqChng    in   one-cycle update request from the rotary block
//   address     in   requested frequency index, sampled when FreqChng = 1
//   rom_en      out  one-cycle ROM read strobe
//   rom_addr    out  ROM read address, held from the strobe until capture
//   rom_data    in   ROM output, valid exactly ROM_LAT cycles after rom_en
//   phase_wrap  in   one-cycle pulse when the accumulator MSB wraps
//   tw_out      out  tuning word driving the phase accumulator
//   tw_load     out  one-cycle pulse in the cycle tw_out takes a new value
//   busy        out  high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module freq_update_ctrl #(
  parameter int ADDR_W   = 11,
  parameter int TW_W     = 32,
  parameter int ROM_LAT  = 2,
  parameter int MAX_ADDR = 1800,
  parameter int WRAP_TMO = 4096
) (
  input  logic              Fg_clk,
  input  logic              Reset,
  input  logic              FreqChng,
  input  logic [ADDR_W-1:0] address,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [TW_W-1:0]   rom_data,
  input  logic              phase_wrap,
  output logic [TW_W-1:0]   tw_out,
  output logic              tw_load,
  output logic              busy
);

  localparam int WAIT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam int TMO_W  = (WRAP_TMO > 1) ? $clog2(WRAP_TMO) : 1;

  localparam logic [ADDR_W-1:0] MAX_A     = ADDR_W'(MAX_ADDR);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(ROM_LAT - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(WRAP_TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ARM,
    S_COMMIT
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic [ADDR_W-1:0]   r_req_addr;
  logic [ADDR_W-1:0]   r_rom_addr;
  logic                r_pending;
  logic                r_init_req;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [TMO_W-1:0]    r_tmo_cnt;
  logic [TW_W-1:0]     r_shadow;
  logic [TW_W-1:0]     r_tw_out;

  logic [ADDR_W-1:0]   w_clamped_addr;
  logic                w_pending_eff;
  logic                w_rom_valid;
  logic                w_commit_go;

  // Out-of-range indices from the rotary block saturate at the top ROM entry.
  assign w_clamped_addr = (address > MAX_A) ? MAX_A : address;

  // A request arriving in the current cycle counts as pending already.
  // Without this, a request coinciding with phase_wrap in ARM would let the
  // stale word through.
  assign w_pending_eff = r_pending | FreqChng;

  // The wait counter reaches zero in exactly the cycle the ROM output is valid.
  assign w_rom_valid = (r_state == S_WAIT) && (r_wait_cnt == '0);

  // The word goes to the accumulator only on the ARM -> COMMIT transition.
  assign w_commit_go = (r_state == S_ARM) && (w_next_state == S_COMMIT);

  // State register.
  always_ff @(posedge Fg_clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. Pending requests always win over committing, so the
  // accumulator never receives a word that has already been superseded.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (FreqChng || r_init_req) begin
          w_next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (r_wait_cnt == '0) begin
          w_next_state = w_pending_eff ? S_FETCH : S_ARM;
        end
      end
      S_ARM: begin
        if (w_pending_eff) begin
          w_next_state = S_FETCH;
        end else if (phase_wrap || (r_tmo_cnt == TMO_LAST)) begin
          w_next_state = S_COMMIT;
        end
      end
      S_COMMIT: begin
        w_next_state = FreqChng ? S_FETCH : S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Request bookkeeping. Only the most recent address is kept. The init flag
  // fetches entry 0 once after reset, so the accumulator starts from a known
  // word. A FreqChng during the FETCH cycle re-arms pending, because the
  // address just sent to the ROM is already out of date.
  always_ff @(posedge Fg_clk or posedge Reset) begin
    if (Reset) begin
      r_req_addr <= '0;
      r_pending  <= 1'b0;
      r_init_req <= 1'b1;
    end else begin
      if (FreqChng) begin
        r_req_addr <= w_clamped_addr;
      end
      if (r_state == S_FETCH) begin
        r_pending <= FreqChng;
      end else if (FreqChng && (r_state != S_IDLE)) begin
        r_pending <= 1'b1;
      end
      if (r_state == S_IDLE) begin
        r_init_req <= 1'b0;
      end
    end
  end

  // ROM read bookkeeping. rom_addr is taken straight from req_addr in the
  // strobe cycle and held afterwards. A later request cannot disturb the
  // address while the ROM is still answering.
  always_ff @(posedge Fg_clk or posedge Reset) begin
    if (Reset) begin
      r_rom_addr <= '0;
      r_wait_cnt <= '0;
      r_shadow   <= '0;
    end else begin
      if (r_state == S_FETCH) begin
        r_rom_addr <= r_req_addr;
        r_wait_cnt <= WAIT_LOAD;
      end else if ((r_state == S_WAIT) && (r_wait_cnt != '0)) begin
        r_wait_cnt <= r_wait_cnt - 1'b1;
      end
      if (w_rom_valid) begin
        r_shadow <= rom_data;
      end
    end
  end

  // Wrap timeout. The counter restarts on every entry into ARM. ARM is left
  // at TMO_LAST at the latest, so the counter cannot overflow while armed.
  always_ff @(posedge Fg_clk or posedge Reset) begin
    if (Reset) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_ARM) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  // Tuning word register. It updates on the edge entering COMMIT, so the new
  // word and tw_load appear together in the COMMIT cycle.
  always_ff @(posedge Fg_clk or posedge Reset) begin
    if (Reset) begin
      r_tw_out <= '0;
    end else if (w_commit_go) begin
      r_tw_out <= r_shadow;
    end
  end

  assign rom_en   = (r_state == S_FETCH);
  assign rom_addr = (r_state == S_FETCH) ? r_req_addr : r_rom_addr;
  assign tw_out   = r_tw_out;
  assign tw_load  = (r_state == S_COMMIT);
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_freq_update_ctrl.sv
// ---------------------------------------------------------------------------
// tb_freq_update_ctrl
//
// Self-checking bench for freq_update_ctrl. A small ROM model answers reads
// with the programmed word in exactly the valid cycle and with junk in every
// other cycle. A behavioural reference tracks the update sequence as timed
// phases and predicts every output each cycle. Directed scenarios pin
// hand-derived values. A randomized phase then exercises request overlap.
// ---------------------------------------------------------------------------
module tb_freq_update_ctrl;

  localparam int ADDR_W   = 11;
  localparam int TW_W     = 32;
  localparam int ROM_LAT  = 2;
  localparam int MAX_ADDR = 1800;
  localparam int WRAP_TMO = 4096;

  logic              Fg_clk = 1'b0;
  logic              Reset = 1'b0;
  logic              FreqChng = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic              phase_wrap = 1'b0;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [TW_W-1:0]   rom_data;
  logic [TW_W-1:0]   tw_out;
  logic              tw_load;
  logic              busy;

  int testsRun = 0;
  int testsFailed = 0;
  int romEnCount = 0;

  freq_update_ctrl #(
    .ADDR_W  (ADDR_W),
    .TW_W    (TW_W),
    .ROM_LAT (ROM_LAT),
    .MAX_ADDR(MAX_ADDR),
    .WRAP_TMO(WRAP_TMO)
  ) dut (
    .Fg_clk    (Fg_clk),
    .Reset     (Reset),
    .FreqChng  (FreqChng),
    .address   (address),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .phase_wrap(phase_wrap),
    .tw_out    (tw_out),
    .tw_load   (tw_load),
    .busy      (busy)
  );

  always #5 Fg_clk = ~Fg_clk;

  // ROM contents: entry 0 is zero, entry 100 is the documented word, and every
  // other entry is a distinct non-zero hash.
  function automatic logic [TW_W-1:0] romWord(input int a);
    logic [31:0] h;
    if (a == 0) return '0;
    if (a == 100) return 32'h00A3_D70A;
    h = 32'(a) * 32'h9E37_79B1;
    return (h ^ 32'h5A5A_0000) | 32'h1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs from a falling edge. The task returns at the
  // next falling edge, by which time the DUT has reacted to that cycle.
  task automatic applyStimulus(input bit fc, input int addr, input bit pw);
    FreqChng   = fc;
    address    = ADDR_W'(addr);
    phase_wrap = pw;
    @(negedge Fg_clk);
    FreqChng   = 1'b0;
    phase_wrap = 1'b0;
  endtask

  // ROM model: a read strobe travels down a ROM_LAT-deep pipe, and the word
  // is presented only in the single valid cycle.
  logic [ROM_LAT-1:0] enPipe;
  logic [ADDR_W-1:0]  addrPipe [ROM_LAT];
  logic [TW_W-1:0]    junk;

  always @(posedge Fg_clk or posedge Reset) begin
    if (Reset) begin
      enPipe <= '0;
      junk   <= '0;
      for (int i = 0; i < ROM_LAT; i++) addrPipe[i] <= '0;
    end else begin
      enPipe[0]   <= rom_en;
      addrPipe[0] <= rom_addr;
      for (int i = 1; i < ROM_LAT; i++) begin
        enPipe[i]   <= enPipe[i-1];
        addrPipe[i] <= addrPipe[i-1];
      end
      junk <= $urandom;
    end
  end

  assign rom_data = enPipe[ROM_LAT-1] ? romWord(int'(addrPipe[ROM_LAT-1])) : junk;

  always @(posedge Fg_clk) begin
    if (!Reset && rom_en) romEnCount <= romEnCount + 1;
  end

  // Behavioural reference. The update is a timeline:
  //   - a read cycle,
  //   - ROM_LAT cycles of ROM latency,
  //   - an armed interval of at most WRAP_TMO cycles,
  //   - a one-cycle hand-over.
  // Any newer request restarts the timeline at a read.
  bit                mInit, mFetch, mCommit, mPending;
  int                mAge, mArm;
  logic [ADDR_W-1:0] mReqAddr, mRomAddr, mFetchedAddr;
  logic [TW_W-1:0]   mShadow, mTwOut;

  always @(posedge Fg_clk or posedge Reset) begin : refModel
    bit nFetch, nCommit, busyNow, pendEff;
    int nAge, nArm;
    logic [ADDR_W-1:0] clamped, nFetched;
    logic [TW_W-1:0] nShadow, nTwOut;
    if (Reset) begin
      mInit <= 1'b1; mFetch <= 1'b0; mCommit <= 1'b0; mPending <= 1'b0;
      mAge <= 0; mArm <= -1;
      mReqAddr <= '0; mRomAddr <= '0; mFetchedAddr <= '0;
      mShadow <= '0; mTwOut <= '0;
    end else begin
      busyNow  = mFetch || (mAge > 0) || (mArm >= 0) || mCommit;
      pendEff  = mPending || FreqChng;
      clamped  = (int'(address) > MAX_ADDR) ? ADDR_W'(MAX_ADDR) : address;
      nFetch   = 1'b0; nCommit = 1'b0; nAge = 0; nArm = -1;
      nShadow  = mShadow; nTwOut = mTwOut; nFetched = mFetchedAddr;
      if (!busyNow) begin
        if (FreqChng || mInit) nFetch = 1'b1;
      end else if (mFetch) begin
        nAge = 1;
        nFetched = mReqAddr;
      end else if (mAge > 0) begin
        if (mAge == ROM_LAT) begin
          nShadow = romWord(int'(mFetchedAddr));
          if (pendEff) nFetch = 1'b1;
          else nArm = 0;
        end else begin
          nAge = mAge + 1;
        end
      end else if (mArm >= 0) begin
        if (pendEff) begin
          nFetch = 1'b1;
        end else if (phase_wrap || (mArm == WRAP_TMO - 1)) begin
          nCommit = 1'b1;
          nTwOut = mShadow;
        end else begin
          nArm = mArm + 1;
        end
      end else begin
        if (FreqChng) nFetch = 1'b1;
      end
      if (mFetch) mPending <= FreqChng;
      else if (busyNow && FreqChng) mPending <= 1'b1;
      mInit        <= mInit && busyNow;
      mRomAddr     <= mFetch ? mReqAddr : mRomAddr;
      mReqAddr     <= FreqChng ? clamped : mReqAddr;
      mFetch       <= nFetch;
      mCommit      <= nCommit;
      mAge         <= nAge;
      mArm         <= nArm;
      mFetchedAddr <= nFetched;
      mShadow      <= nShadow;
      mTwOut       <= nTwOut;
    end
  end

  // Every falling edge: all DUT outputs against the reference.
  always @(negedge Fg_clk) begin
    checkOutput("rom_en", rom_en, mFetch);
    checkOutput("rom_addr", rom_addr, mFetch ? mReqAddr : mRomAddr);
    checkOutput("busy", busy, mFetch || (mAge > 0) || (mArm >= 0) || mCommit);
    checkOutput("tw_load", tw_load, mCommit);
    checkOutput("tw_out", tw_out, mTwOut);
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int startCnt;
    bit fc, pw;

    #1 Reset = 1'b1;
    repeat (3) @(negedge Fg_clk);
    checkOutput("reset tw_out", tw_out, 32'h0);
    checkOutput("reset rom_en", rom_en, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    Reset = 1'b0;

    // Power-up fetch of entry 0, then a forced commit: 1 fetch + ROM_LAT
    // waits + WRAP_TMO armed cycles put the commit 4100 edges after release.
    @(negedge Fg_clk);
    cyc = 1;
    checkOutput("init rom_en", rom_en, 1'b1);
    checkOutput("init rom_addr", rom_addr, 0);
    while (tw_load !== 1'b1 && cyc < 5000) begin
      @(negedge Fg_clk);
      cyc++;
    end
    checkOutput("forced commit cycle", cyc, 4100);
    checkOutput("forced tw_out", tw_out, 32'h0);
    @(negedge Fg_clk);
    checkOutput("idle after forced", busy, 1'b0);

    // Commit on wrap: the word appears with tw_load in the cycle after the wrap.
    applyStimulus(1'b1, 100, 1'b0);
    checkOutput("wrap rom_en", rom_en, 1'b1);
    checkOutput("wrap rom_addr", rom_addr, 100);
    repeat (19) applyStimulus(1'b0, 0, 1'b0);
    checkOutput("wrap no early change", tw_out, 32'h0);
    applyStimulus(1'b0, 0, 1'b1);
    checkOutput("wrap tw_load", tw_load, 1'b1);
    checkOutput("wrap tw_out", tw_out, 32'h00A3_D70A);
    applyStimulus(1'b0, 0, 1'b0);

    // Overwrite while fetching: two reads (5 then 10), one commit of ROM[10].
    startCnt = romEnCount;
    applyStimulus(1'b1, 5, 1'b0);
    checkOutput("ovr first addr", rom_addr, 5);
    applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b1, 10, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("ovr refetch en", rom_en, 1'b1);
    checkOutput("ovr refetch addr", rom_addr, 10);
    repeat (3) applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1);
    checkOutput("ovr tw_out", tw_out, romWord(10));
    checkOutput("ovr read count", romEnCount - startCnt, 2);

    // Abort in ARM: a request coinciding with the wrap wins over the commit.
    applyStimulus(1'b1, 50, 1'b0);
    repeat (3) applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b1, 60, 1'b1);
    checkOutput("abort no load", tw_load, 1'b0);
    checkOutput("abort refetch", rom_addr, 60);
    checkOutput("abort tw_out kept", tw_out, romWord(10));
    repeat (3) applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1);
    checkOutput("abort tw_out", tw_out, romWord(60));

    // Clamp of out-of-range index.
    applyStimulus(1'b1, 2047, 1'b0);
    checkOutput("clamp rom_addr", rom_addr, 1800);
    repeat (3) applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1);
    checkOutput("clamp tw_out", tw_out, romWord(1800));

    // Reset during WAIT: asynchronous clear, then a fresh fetch of entry 0.
    applyStimulus(1'b1, 77, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);
    #2 Reset = 1'b1;
    #1;
    checkOutput("midrst tw_out", tw_out, 32'h0);
    checkOutput("midrst busy", busy, 1'b0);
    checkOutput("midrst rom_en", rom_en, 1'b0);
    repeat (2) @(negedge Fg_clk);
    Reset = 1'b0;
    @(negedge Fg_clk);
    checkOutput("midrst refetch en", rom_en, 1'b1);
    checkOutput("midrst refetch addr", rom_addr, 0);
    repeat (3) applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1);
    checkOutput("midrst tw_load", tw_load, 1'b1);
    checkOutput("midrst tw_out", tw_out, 32'h0);

    // Randomized overlap of requests, wraps and clamps.
    for (int i = 0; i < 3000; i++) begin
      fc = ($urandom_range(0, 24) == 0);
      pw = ($urandom_range(0, 11) == 0);
      applyStimulus(fc, int'($urandom_range(0, 2047)), pw);
    end
    repeat (20) applyStimulus(1'b0, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/freq_update_ctrl.md
Name: freq_update_ctrl

Overview:
Sequences frequency updates for the DDS core. It takes each address/FreqChng event from the rotary front end and fetches the matching tuning word from the synchronous frequency ROM. It commits that word to the phase accumulator only at a phase-wrap boundary, so the output waveform never glitches. It sits between the rotary encoder, the tuning-word ROM and the phase accumulator.

Parameters:
ADDR_W, 11, width of address and ROM address
TW_W, 32, width of tuning word
ROM_LAT, 2, ROM read latency in cycles from rom_en to valid rom_data (1..7)
MAX_ADDR, 1800, highest legal ROM address
WRAP_TMO, 4096, cycles to wait for phase_wrap before a forced commit

Ports:
Fg_clk  in  1  system clock
Reset  in  1  asynchronous reset, active-high
FreqChng  in  1  one-cycle update request from the rotary block
address  in  ADDR_W  requested frequency index, sampled when FreqChng=1
rom_en  out  1  one-cycle ROM read strobe
rom_addr  out  ADDR_W  ROM read address, stable from the rom_en cycle until capture
rom_data  in  TW_W  ROM output, valid exactly ROM_LAT cycles after rom_en
phase_wrap  in  1  one-cycle pulse when the accumulator MSB wraps
tw_out  out  TW_W  tuning word driving the phase accumulator
tw_load  out  1  one-cycle pulse in the cycle tw_out changes
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, Reset=1):
  - Outputs: tw_out=0, tw_load=0, rom_en=0, rom_addr=0, busy=0.
  - Internal: FSM=IDLE, shadow=0, pending=0.
  - Internal init_req=1, so the first cycle after release starts a fetch of address 0.
  - Reset asserted mid-operation aborts immediately; no commit occurs.
- Request capture, any state:
  - FreqChng=1 latches req_addr = min(address, MAX_ADDR).
  - If the FSM is not in IDLE, it also sets pending=1.
  - Later requests overwrite req_addr; only the latest address is honoured.
- FSM states:
  - IDLE:
    - On FreqChng or init_req, go to FETCH next cycle.
    - FreqChng in IDLE does not set pending.
    - Clear init_req.
  - FETCH (1 cycle):
    - rom_en=1, rom_addr=req_addr.
    - Clear pending.
    - Load wait counter with ROM_LAT-1.
    - Go to WAIT.
  - WAIT:
    - Count down.
    - In the cycle rom_data is valid (ROM_LAT cycles after rom_en), shadow<=rom_data.
    - Then: if pending=1, go to FETCH (stale shadow discarded); else go to ARM with tmo counter=0.
  - ARM:
    - Increment tmo counter.
    - On phase_wrap=1, or when tmo counter reaches WRAP_TMO-1, go to COMMIT.
    - If pending=1 (a new request arrived), go to FETCH without committing. Pending has priority over a simultaneous phase_wrap.
  - COMMIT (1 cycle):
    - tw_out<=shadow, tw_load=1.
    - Go to IDLE, or to FETCH if FreqChng=1 in this same cycle.
- Latency: FreqChng in IDLE to tw_load is at least 1 + 1 + ROM_LAT + 1 + (cycles to phase_wrap) + 1.
- Forced commit: covers tw_out=0 (accumulator frozen, no wraps will arrive). Fixed timeout WRAP_TMO.
- tw_out changes only in COMMIT. tw_load is never high for two consecutive cycles.
- FreqChng with the same address as the last commit still runs a full fetch and commit; no suppression.
- busy = (state != IDLE).

Test Plan:
- Reset release, ROM[0]=0, no phase_wrap: fetch of addr 0 → forced commit after WRAP_TMO cycles in ARM. tw_out=0, one tw_load pulse, busy returns 0.
- Commit on wrap: FreqChng with address=100, ROM[100]=0x00A3D70A, phase_wrap 20 cycles later. Required: rom_en one cycle with rom_addr=100; tw_out=0x00A3D70A with tw_load in the cycle after phase_wrap; no change to tw_out before that.
- Overwrite while fetching: FreqChng addr=5, then FreqChng addr=10 during WAIT. Required: two rom_en pulses (5, then 10); a single commit of ROM[10]; ROM[5] is never on tw_out.
- Abort in ARM: commit ROM[50] is pending in ARM; FreqChng addr=60 coincides with phase_wrap. Required: no commit of ROM[50]; refetch 60; later commit ROM[60].
- Clamp: FreqChng address=2047 → rom_addr=1800.
- Mid-operation reset: assert Reset during WAIT. Required: all outputs 0 asynchronously; after release, a fresh fetch of addr 0; no commit of the aborted word.
